fpaddsub_norm_round: RTL and testbench
======================================

Name: fpaddsub_norm_round

Overview:
- Back end of the single-precision FP add/sub datapath.
- Takes the aligned magnitude sum/difference produced from the alignment stage's Mmax/Mmin, plus the common exponent and result sign.
- Iteratively normalises, rounds to nearest-even and packs an IEEE754 single.
- Multi-cycle, with valid/ready handshakes on both sides; sits between the mantissa adder and the result register.

Parameters:
- SHIFT_STEP, 8, maximum left-shift distance per NORM cycle; power of two, 1..32.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept input (high only in IDLE)
- sum  in  51  magnitude sum. Bit 50 = carry; bit 49 = hidden-1 position; bits 48:26 = fraction; bits 25:0 = guard/sticky region.
- es  in  8  common exponent from the alignment stage
- sr  in  1  result sign
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  packed IEEE754 single

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, result=0, internal registers=0.
  - in_ready=1 once rst_n deasserts.
  - Reset asserted mid-operation aborts the operation; no output is produced.
- Internal registers:
  - m[50:0]
  - e[8:0] (9-bit, exponent carry kept)
  - s
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: m=sum, e={0,es}, s=sr; go to NORM.
- NORM (one step per cycle):
  - m==0 → result={0,31'b0}; exact cancellation always gives +0. Go to DONE.
  - m[50]=1 → m=(m>>1) with the shifted-out bit ORed into m[0]; e=e+1; go to ROUND.
  - m[49]=1 → go to ROUND.
  - Otherwise: lz = leading zeros from bit 49 down, k=min(lz,SHIFT_STEP).
    - If e<=k → flush to signed zero: result={s,31'b0}; go to DONE.
    - Else m=m<<k, e=e-k; stay in NORM.
- ROUND (1 cycle):
  - g=m[25], st=|m[24:0], lsb=m[26].
  - Increment f=m[49:26] if g&(st|lsb).
  - Increment carries out of bit 24 → f=f>>1, e=e+1.
  - e>=255 → result={s,8'hFF,23'b0} (infinity).
  - Else result={s,e[7:0],f[22:0]}.
  - Go to DONE.
- DONE:
  - out_valid=1; result held stable.
  - On out_ready → out_valid=0, go to IDLE.
  - No new input is accepted until DONE is exited.
- Latency from accept cycle to out_valid:
  - Pre-normalised or carry case: 3 cycles.
  - Left-shift case: 3+ceil(lz/SHIFT_STEP) cycles.
  - Maximum with SHIFT_STEP=8: 10 cycles.
- Input es=0 is handled as an ordinary exponent; any left shift then underflows to signed zero. Denormals are not produced.
- Simultaneous out_ready and in_valid in DONE: result retires; the input is accepted no earlier than the following cycle, in IDLE.

Optional Feature:
- Macro: FPADDSUB_NORM_STATUS_EN.
- When defined: add output flags[3:0] = {overflow, underflow, zero, inexact}.
  - Registered alongside result; valid with out_valid; cleared on reset.
  - inexact = g|st at ROUND, or any flush/overflow.
- When not defined: the port and its logic are absent; no other change in behaviour.

Decomposition:
- Shared package fpaddsub_pkg:
  - field widths (EXP_W=8, FRAC_W=23, SUM_W=51)
  - bias (127), EXP_MAX (255)
  - state enum {IDLE, NORM, ROUND, DONE}
  - flag bit indices
- One sub-module, fpaddsub_lzc: combinational leading-zero counter over m[49:0], 6-bit count. Reusable by the subtract path.

Test Plan:
- 1.0+1.0: sum={1'b1,50'b0}, es=127, sr=0 → result 0x40000000; out_valid 3 cycles after accept.
- Cancellation: sum=0, es=130, sr=1 → result 0x00000000 (+0); zero flag=1.
- Deep shift: sum=51'h1<<26, es=127, SHIFT_STEP=8 → result 0x34000000; latency 6 cycles.
- Round carry: sum={1'b0,1'b1,23'h7FFFFF,1'b1,25'b0}, es=127 → result 0x40000000.
  - Tie-to-even variant: sum={1'b0,1'b1,23'h0,1'b1,25'b0} → result 0x3F800000 (no round-up).
- Overflow: sum={1'b1,50'b0}, es=254 → result 0x7F800000; overflow flag=1.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles → out_valid and result stable, in_ready=0.
  - Then rst_n=0 mid-NORM on a later operation → out_valid=0 and result=0 immediately; no spurious output after release.

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared widths, constants, state encoding and status-flag bit positions
// for the FP add/sub normalise/round back end.
package fpaddsub_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int SUM_W   = 51;
    localparam int LZC_W   = 6;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_INEXACT   = 0;
endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational leading-zero counter over a 50-bit magnitude (bit 49 first).
// An all-zero input reports 50.
module fpaddsub_lzc
    import fpaddsub_pkg::*;
(
    input  logic [49:0]      val,
    output logic [LZC_W-1:0] count
);
    always_comb begin
        count = 6'd50;
        // Scanning upward lets the most significant set bit win.
        for (int i = 0; i < 50; i++) begin
            if (val[i]) count = 6'(49 - i);
        end
    end
endmodule

// File: rtl/fpaddsub_norm_round.sv
// Iterative normalise, round-to-nearest-even and IEEE754 single pack.
// Optional status port flags[3:0] enabled by FPADDSUB_NORM_STATUS_EN.
module fpaddsub_norm_round
    import fpaddsub_pkg::*;
#(
    parameter int SHIFT_STEP = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  sum,
    input  logic [EXP_W-1:0]  es,
    input  logic              sr,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FPADDSUB_NORM_STATUS_EN
    output logic [3:0]        flags,
`endif
    output logic [31:0]       result
);
    localparam logic [LZC_W-1:0] STEP = LZC_W'(SHIFT_STEP);

    state_t             state, state_next;
    logic [SUM_W-1:0]   m;
    logic [EXP_W:0]     e;
    logic               s;
    logic [31:0]        res;

    logic [LZC_W-1:0]   lz, k;
    logic               m_zero, flush;
    logic               g, st, lsb, inc_up;
    logic [24:0]        f_inc;
    logic [EXP_W:0]     e_rnd;
    logic [FRAC_W-1:0]  frac;
    logic               ovf;

    fpaddsub_lzc u_lzc (
        .val   (m[49:0]),
        .count (lz)
    );

    assign m_zero = (m == '0);
    assign k      = (lz < STEP) ? lz : STEP;
    assign flush  = (e <= {3'b000, k});

    // Rounding of the normalised mantissa; a carry out of the 24-bit
    // significand renormalises by one place and bumps the exponent.
    assign g      = m[25];
    assign st     = |m[24:0];
    assign lsb    = m[26];
    assign inc_up = g & (st | lsb);
    assign f_inc  = {1'b0, m[49:26]} + {24'd0, inc_up};
    assign e_rnd  = e + {8'd0, f_inc[24]};
    assign frac   = f_inc[24] ? f_inc[23:1] : f_inc[22:0];
    assign ovf    = (e_rnd >= 9'(EXP_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_valid) state_next = NORM;
            NORM: begin
                if (m_zero)                state_next = DONE;
                else if (m[50] || m[49])   state_next = ROUND;
                else if (flush)            state_next = DONE;
                else                       state_next = NORM;
            end
            ROUND: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        result    = res;
    end

`ifdef FPADDSUB_NORM_STATUS_EN
    logic [3:0] flag_reg;
    assign flags = flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg <= '0;
        end else if (state == NORM) begin
            if (m_zero) begin
                flag_reg            <= '0;
                flag_reg[FLAG_ZERO] <= 1'b1;
            end else if (!m[50] && !m[49] && flush) begin
                flag_reg                 <= '0;
                flag_reg[FLAG_UNDERFLOW] <= 1'b1;
                flag_reg[FLAG_ZERO]      <= 1'b1;
                flag_reg[FLAG_INEXACT]   <= 1'b1;
            end
        end else if (state == ROUND) begin
            flag_reg                <= '0;
            flag_reg[FLAG_OVERFLOW] <= ovf;
            flag_reg[FLAG_INEXACT]  <= ovf | g | st;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            e   <= '0;
            s   <= 1'b0;
            res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m <= sum;
                        e <= {1'b0, es};
                        s <= sr;
                    end
                end
                NORM: begin
                    if (m_zero) begin
                        res <= '0;
                    end else if (m[50]) begin
                        // Keep the bit shifted out as sticky information.
                        m <= {1'b0, m[50:2], m[1] | m[0]};
                        e <= e + 9'd1;
                    end else if (m[49]) begin
                        m <= m;
                    end else if (flush) begin
                        res <= {s, 31'd0};
                    end else begin
                        m <= m << k;
                        e <= e - {3'b000, k};
                    end
                end
                ROUND: begin
                    if (ovf) res <= {s, 8'hFF, 23'd0};
                    else     res <= {s, e_rnd[7:0], frac};
                end
                default: begin
                    res <= res;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpaddsub_norm_round.sv
// Randomised and directed bench for fpaddsub_norm_round against a
// closed-form reference model of normalise / round / pack.
module tb_fpaddsub_norm_round;
    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [50:0] sum;
    logic [7:0]  es;
    logic        sr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FPADDSUB_NORM_STATUS_EN
    logic [3:0]  flags;
`endif

    int checks = 0;
    int errors = 0;

    fpaddsub_norm_round #(.SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .es        (es),
        .sr        (sr),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FPADDSUB_NORM_STATUS_EN
        .flags     (flags),
`endif
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: flushing happens exactly when the exponent cannot absorb
    // the full leading-zero count, so the normalised value is found in one go.
    task automatic ref_model(input logic [50:0] sm, input logic [7:0] x, input logic sgn,
                             output logic [31:0] r, output logic [3:0] fl, output int lat);
        logic [50:0] mm;
        logic [24:0] f;
        logic        gg, ss, ll;
        int          ee, lz;
        bit          do_round;
        do_round = 1'b1;
        mm = '0;
        ee = 0;
        r  = '0;
        fl = '0;
        lat = 3;
        if (sm == '0) begin
            r = 32'h0; fl = 4'b0010; lat = 2; do_round = 1'b0;
        end else if (sm[50]) begin
            mm = (sm >> 1) | {50'd0, sm[0]};
            ee = int'(x) + 1;
        end else if (sm[49]) begin
            mm = sm;
            ee = int'(x);
        end else begin
            lz = 0;
            for (int i = 49; i >= 0; i--) begin
                if (sm[i]) break;
                lz++;
            end
            if (int'(x) <= lz) begin
                r = {sgn, 31'd0}; fl = 4'b0111; do_round = 1'b0;
                lat = (x == 0) ? 2 : (int'(x) + STEP - 1) / STEP + 1;
            end else begin
                mm = sm << lz;
                ee = int'(x) - lz;
                lat = 3 + (lz + STEP - 1) / STEP;
            end
        end
        if (do_round) begin
            gg = mm[25];
            ss = |mm[24:0];
            ll = mm[26];
            f = {1'b0, mm[49:26]} + ((gg && (ss || ll)) ? 25'd1 : 25'd0);
            if (f[24]) begin
                f = f >> 1;
                ee = ee + 1;
            end
            if (ee >= 255) begin
                r = {sgn, 8'hFF, 23'd0}; fl = 4'b1001;
            end else begin
                r = {sgn, 8'(ee), f[22:0]}; fl = {3'b000, gg | ss};
            end
        end
    endtask

    task automatic run_op(input logic [50:0] sm, input logic [7:0] x, input logic sgn,
                          input logic [31:0] er, input logic [3:0] ef, input int elat,
                          input int hold);
        int n;
        @(negedge clk);
        sum = sm; es = x; sr = sgn; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("out_valid", out_valid, 1);
        check("latency", n, elat);
        check("result", result, er);
`ifdef FPADDSUB_NORM_STATUS_EN
        check("flags", flags, ef);
`else
        if (ef != ef) check("flags_unused", 0, 1);
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, er);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("retire_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] er;
        logic [3:0]  ef;
        logic [63:0] raw;
        logic [50:0] sm;
        logic [7:0]  x;
        int          lat, n, cls;
        bit          seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum = '0; es = '0; sr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        run_op({1'b1, 50'd0}, 8'd127, 1'b0, 32'h40000000, 4'b0000, 3, 0);
        run_op(51'd0, 8'd130, 1'b1, 32'h00000000, 4'b0010, 2, 0);
        run_op(51'd1 << 26, 8'd127, 1'b0, 32'h34000000, 4'b0000, 6, 0);
        run_op({1'b0, 1'b1, 23'h7FFFFF, 1'b1, 25'd0}, 8'd127, 1'b0, 32'h40000000, 4'b0001, 3, 0);
        run_op({1'b0, 1'b1, 23'h000000, 1'b1, 25'd0}, 8'd127, 1'b0, 32'h3F800000, 4'b0001, 3, 0);
        run_op({1'b1, 50'd0}, 8'd254, 1'b0, 32'h7F800000, 4'b1001, 3, 5);
        run_op(51'd1 << 30, 8'd5, 1'b1, 32'h80000000, 4'b0111, 2, 0);

        // Retire and new input in the same DONE cycle: input waits for IDLE.
        @(negedge clk);
        sum = {1'b1, 50'd0}; es = 8'd100; sr = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("overlap_first_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        sum = {1'b1, 50'd0}; es = 8'd127; sr = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("overlap_retired", out_valid, 0);
        check("overlap_not_taken", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("overlap_taken", in_ready, 0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("overlap_latency", n, 3);
        check("overlap_result", result, 32'h40000000);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        for (int t = 0; t < 300; t++) begin
            raw = {$urandom, $urandom};
            cls = $urandom_range(0, 9);
            case (cls)
                0:       sm = '0;
                1, 2:    sm = raw[50:0] | (51'd1 << 50);
                3, 4:    sm = {2'b01, raw[48:0]};
                default: sm = {2'b01, raw[48:0]} >> $urandom_range(1, 49);
            endcase
            if ($urandom_range(0, 3) == 0) sm[24:0] = '0;
            case ($urandom_range(0, 3))
                0:       x = 8'($urandom_range(0, 60));
                1:       x = 8'($urandom_range(240, 255));
                default: x = 8'($urandom_range(0, 255));
            endcase
            ref_model(sm, x, 1'($urandom_range(0, 1)), er, ef, lat);
            run_op(sm, x, er[31], er, ef, lat, $urandom_range(0, 3));
        end

        // Reset during normalisation drops the operation entirely.
        @(negedge clk);
        sum = 51'd1 << 26; es = 8'd127; sr = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", seen, 0);
        check("abort_in_ready", in_ready, 1);
        run_op({1'b1, 50'd0}, 8'd127, 1'b0, 32'h40000000, 4'b0000, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
